// File: rtl/transform_hidx_gen_if.sv
// Layer-control and line-fetch signals of the input-row index generator.
// Master drives configuration/handshake inputs; slave is the generator itself.
interface transform_hidx_gen_if #(
    parameter int C_W_WIDTH = 10,
    parameter int C_KWIDTH  = 4,
    parameter int C_SWIDTH  = 2,
    parameter int C_PWIDTH  = 2,
    parameter int C_DWIDTH  = 2
) ();
    logic                        I_ap_start;
    logic                        I_hcnt_flag;
    logic [C_W_WIDTH-1:0]        I_oheight;
    logic [C_W_WIDTH-1:0]        I_iheight;
    logic [C_KWIDTH-1:0]         I_kernel_h;
    logic [C_SWIDTH-1:0]         I_stride_h;
    logic [C_PWIDTH-1:0]         I_pad_h;
    logic [C_DWIDTH-1:0]         I_dilation_h;
    logic [C_W_WIDTH-1:0]        O_oh;
    logic [C_W_WIDTH-1:0]        O_h;
    logic [C_KWIDTH-1:0]         O_kh;
    logic signed [C_W_WIDTH:0]   O_hindex;
    logic                        O_hvalid;
    logic                        O_compute_en;
    logic                        O_first_line;
    logic                        O_last_line;
    logic                        O_done;

    modport master (
        output I_ap_start, I_hcnt_flag, I_oheight, I_iheight, I_kernel_h,
               I_stride_h, I_pad_h, I_dilation_h,
        input  O_oh, O_h, O_kh, O_hindex, O_hvalid, O_compute_en,
               O_first_line, O_last_line, O_done
    );

    modport slave (
        input  I_ap_start, I_hcnt_flag, I_oheight, I_iheight, I_kernel_h,
               I_stride_h, I_pad_h, I_dilation_h,
        output O_oh, O_h, O_kh, O_hindex, O_hvalid, O_compute_en,
               O_first_line, O_last_line, O_done
    );
endinterface

// File: rtl/transform_hidx_gen.sv
// Walks output rows and kernel rows of one layer, producing the signed input row index.
// Optional macro TRANSFORM_HIDX_DILATION_EN enables a latched vertical dilation step.
module transform_hidx_gen #(
    parameter int C_W_WIDTH = 10,
    parameter int C_KWIDTH  = 4,
    parameter int C_SWIDTH  = 2,
    parameter int C_PWIDTH  = 2,
    parameter int C_DWIDTH  = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    transform_hidx_gen_if.slave  bus
);
    localparam int HW = C_W_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    state_t                state_next;

    logic                  start_prev;
    logic                  start_edge;
    logic                  accept;
    logic                  empty_layer;

    logic [C_W_WIDTH-1:0]  oheight_r;
    logic [C_W_WIDTH-1:0]  iheight_r;
    logic [C_KWIDTH-1:0]   kernel_r;
    logic [C_SWIDTH-1:0]   stride_r;
    logic [C_PWIDTH-1:0]   pad_r;

    logic [C_W_WIDTH-1:0]  oh;
    logic [C_W_WIDTH-1:0]  h;
    logic [C_KWIDTH-1:0]   kh;
    logic [HW-1:0]         hindex;

    logic [C_W_WIDTH-1:0]  dil_step;
    logic [C_W_WIDTH-1:0]  h_next;
    logic                  kh_last;
    logic                  oh_last;
    logic                  hvalid;
    logic                  step;

    assign start_edge  = bus.I_ap_start & ~start_prev;
    assign accept      = (state == IDLE) & start_edge;
    assign empty_layer = (bus.I_oheight == '0) | (bus.I_kernel_h == '0);

    assign kh_last = (kh == kernel_r - C_KWIDTH'(1));
    assign oh_last = (oh == oheight_r - C_W_WIDTH'(1));
    assign h_next  = h + C_W_WIDTH'(stride_r);

    // Padded rows (negative or past the bottom) never wait for the PE.
    assign hvalid = (state == RUN) & ~hindex[HW-1] & (hindex[C_W_WIDTH-1:0] < iheight_r);
    assign step   = (state == RUN) & (~hvalid | bus.I_hcnt_flag);

`ifdef TRANSFORM_HIDX_DILATION_EN
    logic [C_DWIDTH-1:0]   dil_r;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            dil_r <= '0;
        end else if (accept) begin
            dil_r <= (bus.I_dilation_h == '0) ? C_DWIDTH'(1) : bus.I_dilation_h;
        end
    end

    assign dil_step = C_W_WIDTH'(dil_r);
`else
    logic                  unused_dilation;

    assign unused_dilation = ^bus.I_dilation_h;
    assign dil_step        = C_W_WIDTH'(1);
`endif

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = empty_layer ? DONE : RUN;
                end
            end
            RUN: begin
                if (step & kh_last & oh_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Configuration is captured only on an accepted start; counters step incrementally.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            start_prev <= 1'b0;
            oheight_r  <= '0;
            iheight_r  <= '0;
            kernel_r   <= '0;
            stride_r   <= '0;
            pad_r      <= '0;
            oh         <= '0;
            h          <= '0;
            kh         <= '0;
            hindex     <= '0;
        end else begin
            start_prev <= bus.I_ap_start;
            if (accept) begin
                oheight_r <= bus.I_oheight;
                iheight_r <= bus.I_iheight;
                kernel_r  <= bus.I_kernel_h;
                stride_r  <= (bus.I_stride_h == '0) ? C_SWIDTH'(1) : bus.I_stride_h;
                pad_r     <= bus.I_pad_h;
                oh        <= '0;
                h         <= '0;
                kh        <= '0;
                hindex    <= empty_layer ? '0 : (HW'(0) - HW'(bus.I_pad_h));
            end else if (step) begin
                if (kh_last) begin
                    kh <= '0;
                    if (oh_last) begin
                        oh     <= '0;
                        h      <= '0;
                        hindex <= '0;
                    end else begin
                        oh     <= oh + C_W_WIDTH'(1);
                        h      <= h_next;
                        hindex <= {1'b0, h_next} - HW'(pad_r);
                    end
                end else begin
                    kh     <= kh + C_KWIDTH'(1);
                    hindex <= hindex + HW'(dil_step);
                end
            end
        end
    end

    assign bus.O_oh         = oh;
    assign bus.O_h          = h;
    assign bus.O_kh         = kh;
    assign bus.O_hindex     = hindex;
    assign bus.O_hvalid     = hvalid;
    assign bus.O_compute_en = (state == RUN);
    assign bus.O_first_line = (state == RUN) & (oh == '0);
    assign bus.O_last_line  = (state == RUN) & oh_last;
    assign bus.O_done       = (state == DONE);
endmodule

// File: tb/tb_transform_hidx_gen.sv
// Directed and randomized layers for transform_hidx_gen, checked against a row-list model
// built from oh*stride + kh*dilation - pad.
module tb_transform_hidx_gen;
    localparam int W  = 10;
    localparam int KW = 4;
    localparam int SW = 2;
    localparam int PW = 2;
    localparam int DW = 2;

    typedef struct {
        int oh;
        int h;
        int kh;
        int hidx;
        bit valid;
        bit first;
        bit last;
    } row_t;

    logic I_clk = 1'b0;
    logic I_rst;
    int   test_count = 0;
    int   fail_count = 0;
    row_t exp_rows[$];

    transform_hidx_gen_if #(.C_W_WIDTH(W), .C_KWIDTH(KW), .C_SWIDTH(SW),
                            .C_PWIDTH(PW), .C_DWIDTH(DW)) bus ();

    transform_hidx_gen #(.C_W_WIDTH(W), .C_KWIDTH(KW), .C_SWIDTH(SW),
                         .C_PWIDTH(PW), .C_DWIDTH(DW)) dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .bus   (bus)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void buildModel(input int ohn, input int ih, input int k,
                                       input int s, input int p, input int d);
        int   se;
        int   de;
        row_t r;
        exp_rows.delete();
        se = (s == 0) ? 1 : s;
`ifdef TRANSFORM_HIDX_DILATION_EN
        de = (d == 0) ? 1 : d;
`else
        de = 1 + 0 * d;
`endif
        if (ohn == 0 || k == 0) return;
        for (int o = 0; o < ohn; o++) begin
            for (int kk = 0; kk < k; kk++) begin
                r.oh    = o;
                r.h     = o * se;
                r.kh    = kk;
                r.hidx  = o * se + kk * de - p;
                r.valid = (r.hidx >= 0) && (r.hidx < ih);
                r.first = (o == 0);
                r.last  = (o == ohn - 1);
                exp_rows.push_back(r);
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkRow(input row_t r, input int idx);
        checkOutput($sformatf("row%0d.compute_en", idx), 32'(bus.O_compute_en), 1);
        checkOutput($sformatf("row%0d.oh", idx),         32'(bus.O_oh), r.oh);
        checkOutput($sformatf("row%0d.h", idx),          32'(bus.O_h), r.h);
        checkOutput($sformatf("row%0d.kh", idx),         32'(bus.O_kh), r.kh);
        checkOutput($sformatf("row%0d.hindex", idx),     32'(bus.O_hindex), r.hidx);
        checkOutput($sformatf("row%0d.hvalid", idx),     32'(bus.O_hvalid), 32'(r.valid));
        checkOutput($sformatf("row%0d.first", idx),      32'(bus.O_first_line), 32'(r.first));
        checkOutput($sformatf("row%0d.last", idx),       32'(bus.O_last_line), 32'(r.last));
        checkOutput($sformatf("row%0d.done", idx),       32'(bus.O_done), 0);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".compute_en"}, 32'(bus.O_compute_en), 0);
        checkOutput({tag, ".done"},       32'(bus.O_done), 0);
        checkOutput({tag, ".hvalid"},     32'(bus.O_hvalid), 0);
    endtask

    // One whole layer; flag_delay < 0 picks a random PE latency per valid row.
    task automatic applyStimulus(input int ohn, input int ih, input int k, input int s,
                                 input int p, input int d, input int flag_delay,
                                 input bit glitch);
        int dly;
        bus.I_oheight    = W'(ohn);
        bus.I_iheight    = W'(ih);
        bus.I_kernel_h   = KW'(k);
        bus.I_stride_h   = SW'(s);
        bus.I_pad_h      = PW'(p);
        bus.I_dilation_h = DW'(d);
        bus.I_ap_start   = 1'b1;
        buildModel(ohn, ih, k, s, p, d);
        @(negedge I_clk);
        bus.I_oheight    = W'($urandom);
        bus.I_iheight    = W'($urandom);
        bus.I_kernel_h   = KW'($urandom);
        bus.I_stride_h   = SW'($urandom);
        bus.I_pad_h      = PW'($urandom);
        bus.I_dilation_h = DW'($urandom);
        for (int i = 0; i < exp_rows.size(); i++) begin
            checkRow(exp_rows[i], i);
            if (glitch && exp_rows.size() >= 2 && i == 0) bus.I_ap_start = 1'b0;
            if (glitch && exp_rows.size() >= 2 && i == 1) bus.I_ap_start = 1'b1;
            if (exp_rows[i].valid) begin
                dly = (flag_delay < 0) ? int'($urandom_range(0, 3)) : flag_delay;
                repeat (dly) begin
                    @(negedge I_clk);
                    checkOutput($sformatf("hold%0d.hindex", i), 32'(bus.O_hindex),
                                exp_rows[i].hidx);
                end
                bus.I_hcnt_flag = 1'b1;
                @(negedge I_clk);
                bus.I_hcnt_flag = 1'b0;
            end else begin
                bus.I_hcnt_flag = 1'($urandom_range(0, 1));
                @(negedge I_clk);
                bus.I_hcnt_flag = 1'b0;
            end
        end
        checkOutput("end.done",       32'(bus.O_done), 1);
        checkOutput("end.compute_en", 32'(bus.O_compute_en), 0);
        checkOutput("end.last",       32'(bus.O_last_line), 0);
        checkOutput("end.hvalid",     32'(bus.O_hvalid), 0);
        @(negedge I_clk);
        checkOutput("end.done_pulse", 32'(bus.O_done), 0);
        repeat (3) begin
            @(negedge I_clk);
            checkQuiet("held_start");
        end
        bus.I_ap_start = 1'b0;
        @(negedge I_clk);
    endtask

    initial begin
        I_rst            = 1'b1;
        bus.I_ap_start   = 1'b0;
        bus.I_hcnt_flag  = 1'b0;
        bus.I_oheight    = '0;
        bus.I_iheight    = '0;
        bus.I_kernel_h   = '0;
        bus.I_stride_h   = '0;
        bus.I_pad_h      = '0;
        bus.I_dilation_h = '0;
        repeat (2) @(negedge I_clk);
        checkQuiet("reset");
        checkOutput("reset.oh",     32'(bus.O_oh), 0);
        checkOutput("reset.hindex", 32'(bus.O_hindex), 0);
        checkOutput("reset.first",  32'(bus.O_first_line), 0);
        I_rst = 1'b0;
        @(negedge I_clk);

        applyStimulus(4, 4, 3, 1, 1, 1, 2, 1'b0);
        applyStimulus(3, 7, 3, 2, 0, 1, 1, 1'b1);
        applyStimulus(2, 5, 3, 1, 2, 2, 0, 1'b0);
        applyStimulus(0, 4, 3, 1, 0, 1, 0, 1'b0);
        applyStimulus(3, 4, 0, 1, 0, 1, 0, 1'b0);
        applyStimulus(2, 3, 2, 0, 0, 0, 1, 1'b0);

        repeat (4) begin
            bus.I_hcnt_flag = 1'b1;
            @(negedge I_clk);
            bus.I_hcnt_flag = 1'b0;
            checkQuiet("idle_flag");
        end

        bus.I_oheight  = W'(4);
        bus.I_iheight  = W'(4);
        bus.I_kernel_h = KW'(3);
        bus.I_stride_h = SW'(1);
        bus.I_pad_h    = PW'(1);
        bus.I_ap_start = 1'b1;
        @(negedge I_clk);
        @(negedge I_clk);
        repeat (2) begin
            bus.I_hcnt_flag = 1'b1;
            @(negedge I_clk);
            bus.I_hcnt_flag = 1'b0;
        end
        checkOutput("abort.pre_oh",     32'(bus.O_oh), 1);
        checkOutput("abort.pre_hindex", 32'(bus.O_hindex), 0);
        #2;
        I_rst          = 1'b1;
        bus.I_ap_start = 1'b0;
        #1;
        checkQuiet("abort");
        checkOutput("abort.oh",     32'(bus.O_oh), 0);
        checkOutput("abort.h",      32'(bus.O_h), 0);
        checkOutput("abort.kh",     32'(bus.O_kh), 0);
        checkOutput("abort.hindex", 32'(bus.O_hindex), 0);
        checkOutput("abort.last",   32'(bus.O_last_line), 0);
        repeat (2) begin
            @(negedge I_clk);
            checkQuiet("abort_hold");
        end
        I_rst = 1'b0;
        @(negedge I_clk);
        applyStimulus(4, 4, 3, 1, 1, 1, 1, 1'b0);

        repeat (8) begin
            applyStimulus(int'($urandom_range(1, 5)), int'($urandom_range(1, 8)),
                          int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          -1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule

// File: doc/transform_hidx_gen.md
Name: transform_hidx_gen

Overview:
Parametrised successor to the row-index counter in the convolution transform path. It walks output rows (oh) and kernel rows (kh) for one layer and produces the input row index each kernel tap needs. It flags padded rows explicitly, skips top/bottom padding automatically, and supports stride, optional dilation and start/done handshaking. It sits between the layer controller (start/done) and the line-fetch PE (I_hcnt_flag per consumed line).

Parameters:
C_W_WIDTH, 10, width of height and row counters
C_KWIDTH, 4, width of kernel height
C_SWIDTH, 2, width of stride
C_PWIDTH, 2, width of pad
C_DWIDTH, 2, width of dilation

Ports:
I_clk  in  1  clock
I_rst  in  1  asynchronous active-high reset
I_ap_start  in  1  level start; its rising edge launches one layer
I_hcnt_flag  in  1  one-cycle pulse: PE finished the current valid line
I_oheight  in  C_W_WIDTH  output height
I_iheight  in  C_W_WIDTH  input height (unpadded)
I_kernel_h  in  C_KWIDTH  kernel height
I_stride_h  in  C_SWIDTH  vertical stride; 0 treated as 1
I_pad_h  in  C_PWIDTH  top pad
I_dilation_h  in  C_DWIDTH  dilation; used only with macro, 0 treated as 1
O_oh  out  C_W_WIDTH  current output row
O_h  out  C_W_WIDTH  oh*stride
O_kh  out  C_KWIDTH  current kernel row
O_hindex  out  C_W_WIDTH+1  signed, O_h + kh*dil - pad
O_hvalid  out  1  current row is inside [0, iheight)
O_compute_en  out  1  high while RUN
O_first_line  out  1  RUN and oh==0
O_last_line  out  1  RUN and oh==oheight-1
O_done  out  1  one-cycle pulse at end of layer

Behaviour:
- Reset: async, state IDLE. All counters and outputs 0; O_hindex 0.
- Start detect: I_ap_start registered; rising edge = I_ap_start & ~prev. Ignored unless state IDLE.
- On accepted start, latch oheight, iheight, kernel_h, stride, pad and dilation.
- oheight==0 or kernel_h==0: go to DONE. Otherwise go to RUN with oh=0, kh=0, h=0, hindex=-pad.
- FSM states:
  - IDLE: wait for accepted start.
  - RUN: O_compute_en=1.
  - DONE: O_done=1 for exactly one cycle, then IDLE.
- RUN is entered on the cycle after the sampled start edge.
- Step condition in RUN: (O_hvalid & I_hcnt_flag) | ~O_hvalid.
  - Padded rows auto-advance one per cycle.
  - I_hcnt_flag on a padded row, or outside RUN, is ignored.
- On step:
  - If kh==kernel_h-1: kh=0 and kh offset=0. If oh==oheight-1, go to DONE; else oh+=1 and h+=stride.
  - Otherwise: kh+=1 and kh offset+=dil.
- Outputs are registered and reflect the new position the cycle after the step.
- Arithmetic: incremental adders only, no divide or modulo.
  - O_hindex = h + khoff - pad, signed, C_W_WIDTH+1 bits.
  - Configuration guarantees (oheight-1)*stride + (kernel_h-1)*dil < 2^C_W_WIDTH.
- O_hvalid = RUN & ~O_hindex[MSB] & (O_hindex < iheight). Bottom padding also auto-skips.
- On the DONE transition: O_compute_en and O_last_line drop, and O_done pulses in the same cycle.
- I_ap_start held high does not retrigger; a new layer needs a low then high.
- Configuration inputs may change during RUN without effect.
- Reset mid-RUN aborts immediately; no O_done is issued.

Optional Feature:
TRANSFORM_HIDX_DILATION_EN
- Defined: I_dilation_h is latched at start and used as the kh step (0 treated as 1).
- Undefined: dilation is fixed at 1. I_dilation_h is ignored and the khoff adder reduces to a kh copy.

Test Plan:
- oheight=4, iheight=4, K=3, S=1, P=1, flag 2 cycles after each valid row:
  - hindex sequence -1,0,1 | 0,1,2 | 1,2,3 | 2,3,4.
  - -1 and 4 have hvalid=0 and advance in 1 cycle with no flag.
  - 10 flags total; O_done pulses once.
- S=2, K=3, P=0, oheight=3, iheight=7:
  - O_h 0,2,4; hindex 0..2, 2..4, 4..6.
  - O_last_line high only during oh=2.
- With macro, D=2, K=3, P=2, oheight=2, iheight=5:
  - hindex -2,0,2 | -1,1,3.
  - Rows -2 and -1 are skipped.
  - Without macro, the same stimulus gives -2,-1,0 | -1,0,1.
- oheight=0: start -> O_done the next cycle, O_compute_en never high.
- Reset asserted mid-RUN at oh=1: all outputs 0 asynchronously, no O_done. A new start edge after release runs from oh=0.
- Second start edge during RUN and I_hcnt_flag pulses in IDLE: no effect on sequence or counters.
